// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a shared two-stage ALU.
// One operation in flight: latch, issue, execute, capture, then hold the response.
module alu_arb_ctrl #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_opa,
    input  logic [2*W-1:0] req_opb,
    input  logic [7:0]     req_cmd,
    input  logic [1:0]     req_mode,
    input  logic [1:0]     req_cin,
    input  logic [3:0]     req_inp_valid,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_result,
    output logic [5:0]     rsp_flags,
    output logic           alu_ce,
    output logic           alu_mode,
    output logic           alu_cin,
    output logic [3:0]     alu_cmd,
    output logic [1:0]     alu_inp_valid,
    output logic [W-1:0]   alu_opa,
    output logic [W-1:0]   alu_opb,
    input  logic [2*W-1:0] alu_result,
    input  logic           alu_oflow,
    input  logic           alu_cout,
    input  logic           alu_g,
    input  logic           alu_l,
    input  logic           alu_e,
    input  logic           alu_err,
    output logic           busy,
    output logic [15:0]    op_count
);

    typedef enum logic [2:0] {IDLE, ISSUE, EXEC, CAPTURE, RESP} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_last;
    logic           w_gnt_id;
    logic           w_xfer;
    logic [W-1:0]   r_opa;
    logic [W-1:0]   r_opb;
    logic [3:0]     r_cmd;
    logic           r_mode;
    logic           r_cin;
    logic [1:0]     r_inp_valid;
    logic           r_id;
    logic           r_rsp_id;
    logic [2*W-1:0] r_rsp_result;
    logic [5:0]     r_rsp_flags;
    logic [15:0]    r_op_count;

    // On a tie the requester that did not win last time is favoured.
    assign w_gnt_id = (req_valid == 2'b11) ? ~r_last : req_valid[1];
    assign w_xfer   = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 2'b00;
        alu_ce    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (req_valid == 2'b11) begin
                    req_ready = r_last ? 2'b01 : 2'b10;
                end else begin
                    req_ready = req_valid;
                end
                if (|req_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                alu_ce = 1'b1;
                w_next = EXEC;
            end
            EXEC: begin
                alu_ce = 1'b1;
                w_next = CAPTURE;
            end
            CAPTURE: begin
                w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ALU drive registers move only on an accepted request so the ALU's
    // unregistered inputs stay stable for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last       <= 1'b1;
            r_opa        <= '0;
            r_opb        <= '0;
            r_cmd        <= '0;
            r_mode       <= 1'b0;
            r_cin        <= 1'b0;
            r_inp_valid  <= '0;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_xfer) begin
                r_last      <= w_gnt_id;
                r_id        <= w_gnt_id;
                r_opa       <= w_gnt_id ? req_opa[2*W-1:W] : req_opa[W-1:0];
                r_opb       <= w_gnt_id ? req_opb[2*W-1:W] : req_opb[W-1:0];
                r_cmd       <= w_gnt_id ? req_cmd[7:4] : req_cmd[3:0];
                r_mode      <= w_gnt_id ? req_mode[1] : req_mode[0];
                r_cin       <= w_gnt_id ? req_cin[1] : req_cin[0];
                r_inp_valid <= w_gnt_id ? req_inp_valid[3:2] : req_inp_valid[1:0];
            end
            if (r_state == CAPTURE) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
                r_rsp_id     <= r_id;
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign alu_opa       = r_opa;
    assign alu_opb       = r_opb;
    assign alu_cmd       = r_cmd;
    assign alu_mode      = r_mode;
    assign alu_cin       = r_cin;
    assign alu_inp_valid = r_inp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_result    = r_rsp_result;
    assign rsp_flags     = r_rsp_flags;
    assign op_count      = r_op_count;

endmodule
